// File: rtl/mio_bus_ctrl.sv
// ----------------------------------------------------------------------------
// mio_bus_ctrl
//   Memory-mapped I/O bus controller between the CPU data port and NUM_CH
//   peripheral channels. Decodes addr[AW-1:AW-4] against CH_TAG (lowest
//   matching channel wins), runs a request/ack handshake with wait states,
//   aborts an access after TIMEOUT cycles without ack, and reports errors
//   (timeout or unmapped address) with bus_err, ERR_DATA and a saturating
//   error counter.
//
//   Optional feature macro: MIO_WPOST_EN
//     Defined   : mapped writes are posted into a FIFO_DEPTH-entry FIFO and
//                 acknowledged one cycle later; a drain engine replays them
//                 through ACCESS/DONE. Reads wait until the FIFO is drained.
//     Undefined : no FIFO; writes are handled exactly like reads.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request (req held until cpu_ready)
//   cpu_rdata, cpu_ready   read data and one-cycle completion pulse
//   bus_err, err_count     one-cycle error pulse, saturating error counter
//   ch_sel, ch_we          one-hot channel select and write strobe
//   ch_addr, ch_wdata      latched address / write data to the channels
//   ch_rdata, ch_ack       flat per-channel read data and completion
// ----------------------------------------------------------------------------
module mio_bus_ctrl #(
    parameter int                   DW         = 32,
    parameter int                   AW         = 32,
    parameter int                   NUM_CH     = 4,
    parameter logic [NUM_CH*4-1:0]  CH_TAG     = {4'hF, 4'hE, 4'hD, 4'hC},
    parameter int                   TIMEOUT    = 15,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [DW-1:0]        ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_ready,
    output logic                 bus_err,
    output logic [7:0]           err_count,
    output logic [NUM_CH-1:0]    ch_sel,
    output logic [NUM_CH-1:0]    ch_we,
    output logic [AW-1:0]        ch_addr,
    output logic [DW-1:0]        ch_wdata,
    input  logic [NUM_CH*DW-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]    ch_ack
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] sel_q, sel_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              posted_q, posted_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic              ack_hit;
    logic [DW-1:0]     sel_rdata;
    logic              np_go;
    logic              done_np;

    // Lowest channel index with a matching tag wins; all-zero means unmapped.
    function automatic logic [NUM_CH-1:0] decode(input logic [AW-1:0] a);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (a[AW-1 -: 4] == CH_TAG[4*k +: 4]) begin
                oh    = '0;
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Acks from channels that are not selected are masked off here.
    assign ack_hit = |(ch_ack & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q[k]) sel_rdata = ch_rdata[k*DW +: DW];
        end
    end

`ifdef MIO_WPOST_EN
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   fcnt_q;
    logic          post_ack_q;
    logic          push, pop;

    // post_ack_q blocks a second push of the same write during its ready cycle.
    assign push = cpu_req && cpu_we && (decode(cpu_addr) != '0) &&
                  (fcnt_q != FULL_CNT) && !post_ack_q;
    // The head entry stays in the FIFO until its drain access completes, so a
    // full FIFO only frees a slot once the channel has acked (or timed out).
    assign pop  = posted_q && (state_q == ACCESS) && (state_d == DONE);
    // Reads and unmapped writes wait for the FIFO to drain completely.
    assign np_go = cpu_req && (fcnt_q == '0) && !(cpu_we && (decode(cpu_addr) != '0));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wp_q] <= cpu_addr;
            fifo_data_q[wp_q] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q       <= '0;
            rp_q       <= '0;
            fcnt_q     <= '0;
            post_ack_q <= 1'b0;
        end else begin
            post_ack_q <= push;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end
`else
    assign np_go = cpu_req;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        posted_d = posted_q;
        cnt_d    = cnt_q;
        errcnt_d = errcnt_q;
        case (state_q)
            IDLE: begin
`ifdef MIO_WPOST_EN
                if (fcnt_q != '0) begin
                    state_d  = ACCESS;
                    sel_d    = decode(fifo_addr_q[rp_q]);
                    we_d     = 1'b1;
                    addr_d   = fifo_addr_q[rp_q];
                    wdata_d  = fifo_data_q[rp_q];
                    err_d    = 1'b0;
                    posted_d = 1'b1;
                    cnt_d    = '0;
                end else
`endif
                if (np_go) begin
                    // Unmapped accesses still pass through one ACCESS cycle
                    // (with nothing selected) so every non-posted access has
                    // the same three-cycle minimum latency.
                    state_d  = ACCESS;
                    sel_d    = decode(cpu_addr);
                    we_d     = cpu_we;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    err_d    = 1'b0;
                    posted_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is tested first so an ack on the timeout cycle succeeds.
                if (ack_hit) begin
                    state_d = DONE;
                    sel_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = we_q ? ERR_DATA : sel_rdata;
                end else if ((sel_q == '0) || (cnt_q + 8'd1 == TO_CNT)) begin
                    state_d = DONE;
                    sel_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            posted_q <= 1'b0;
            cnt_q    <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            posted_q <= posted_d;
            cnt_q    <= cnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Drained posted writes finish silently: no cpu_ready for them.
    assign done_np   = (state_q == DONE) && !posted_q;
`ifdef MIO_WPOST_EN
    assign cpu_ready = done_np || post_ack_q;
`else
    assign cpu_ready = done_np;
`endif
    assign cpu_rdata = done_np ? rdata_q : '0;
    assign bus_err   = (state_q == DONE) && err_q;
    assign err_count = errcnt_q;
    assign ch_sel    = sel_q;
    assign ch_we     = sel_q & {NUM_CH{we_q}};
    assign ch_addr   = addr_q;
    assign ch_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
module tb_mio_bus_ctrl;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         bus_err;
    logic [7:0]   err_count;
    logic [3:0]   ch_sel;
    logic [3:0]   ch_we;
    logic [31:0]  ch_addr;
    logic [31:0]  ch_wdata;
    logic [127:0] ch_rdata;
    logic [3:0]   ch_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mio_bus_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .bus_err   (bus_err),
        .err_count (err_count),
        .ch_sel    (ch_sel),
        .ch_we     (ch_we),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_ack    (ch_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef MIO_WPOST_EN
    int acks = 0;
    always @(posedge clk) if (rstn && ch_sel[0] && ch_ack[0]) acks = acks + 1;

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (cpu_ready !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask
`endif

    initial begin
        rstn      = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ch_ack    = '0;
        ch_rdata  = {32'h3333_3333, 32'hCAFE_0002, 32'h1111_2222, 32'h1234_5678};
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", cpu_ready, 0);
        chk("rst_sel", ch_sel, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_rdata", cpu_rdata, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: read ch0, ack in first ACCESS cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0004;
        @(negedge clk);
        chk("t1_sel", ch_sel, 4'b0001);
        chk("t1_addr", ch_addr, 32'hC000_0004);
        chk("t1_early_ready", cpu_ready, 0);
        ch_ack = 4'b0001;
        @(negedge clk);
        chk("t1_ready", cpu_ready, 1);
        chk("t1_rdata", cpu_rdata, 32'h1234_5678);
        chk("t1_err", bus_err, 0);
        chk("t1_sel_done", ch_sel, 0);
        cpu_req = 1'b0; ch_ack = '0;
        @(negedge clk);
        chk("t1_ready_1cyc", cpu_ready, 0);

`ifndef MIO_WPOST_EN
        // 2: write ch3, ack withheld 5 cycles -> 6 ACCESS cycles
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hF000_0010; cpu_wdata = 32'h0000_00A5;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("t2_we", ch_we, 4'b1000);
            chk("t2_wdata", ch_wdata, 32'h0000_00A5);
            chk("t2_not_ready", cpu_ready, 0);
            if (i == 6) ch_ack = 4'b1000;
        end
        @(negedge clk);
        chk("t2_ready", cpu_ready, 1);
        chk("t2_we_done", ch_we, 0);
        chk("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t2_err", bus_err, 0);
        cpu_req = 1'b0; cpu_we = 1'b0; ch_ack = '0;
        @(negedge clk);
`endif

        // 3: read ch1, never acked (other channels ack, must be ignored)
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hD000_0000; ch_ack = 4'b1101;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("t3_sel", ch_sel, 4'b0010);
            chk("t3_not_ready", cpu_ready, 0);
        end
        @(negedge clk);
        chk("t3_ready", cpu_ready, 1);
        chk("t3_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t3_err", bus_err, 1);
        chk("t3_errcnt", err_count, 1);
        cpu_req = 1'b0; ch_ack = '0;
        @(negedge clk);
        chk("t3_err_pulse", bus_err, 0);
        chk("t3_errcnt_hold", err_count, 1);

        // 3b: ack on the cycle the counter reaches TIMEOUT counts as success
        cpu_req = 1'b1; cpu_addr = 32'hD000_0000;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 15) ch_ack = 4'b0010;
        end
        @(negedge clk);
        chk("t3b_ready", cpu_ready, 1);
        chk("t3b_rdata", cpu_rdata, 32'h1111_2222);
        chk("t3b_err", bus_err, 0);
        chk("t3b_errcnt", err_count, 1);
        cpu_req = 1'b0; ch_ack = '0;
        @(negedge clk);

        // 4: unmapped read
        cpu_req = 1'b1; cpu_addr = 32'h1000_0000;
        @(negedge clk);
        chk("t4_sel", ch_sel, 0);
        chk("t4_not_ready", cpu_ready, 0);
        @(negedge clk);
        chk("t4_ready", cpu_ready, 1);
        chk("t4_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t4_err", bus_err, 1);
        chk("t4_errcnt", err_count, 2);
        chk("t4_sel_done", ch_sel, 0);
        cpu_req = 1'b0;
        @(negedge clk);

        // 5: reset asserted during ACCESS
        cpu_req = 1'b1; cpu_addr = 32'hE000_0000;
        @(negedge clk);
        chk("t5_sel", ch_sel, 4'b0100);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_sel", ch_sel, 0);
        chk("t5_rst_ready", cpu_ready, 0);
        chk("t5_rst_errcnt", err_count, 0);
        chk("t5_rst_addr", ch_addr, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_ready", cpu_ready, 0);
        end
        cpu_req = 1'b1; cpu_addr = 32'hE000_0000;
        @(negedge clk);
        chk("t5_sel2", ch_sel, 4'b0100);
        ch_ack = 4'b0100;
        @(negedge clk);
        chk("t5_ready", cpu_ready, 1);
        chk("t5_rdata", cpu_rdata, 32'hCAFE_0002);
        chk("t5_err", bus_err, 0);
        cpu_req = 1'b0; ch_ack = '0;
        @(negedge clk);

`ifdef MIO_WPOST_EN
        // 6: posted writes with the first drain held off
        begin
            int n;
            int base;
            base = acks;
            for (int w = 1; w <= 5; w++) begin
                cpu_req = 1'b1; cpu_we = 1'b1;
                cpu_addr = 32'hC000_0000 + 32'(w * 4); cpu_wdata = 32'(w);
                if (w == 5) begin
                    repeat (2) begin
                        @(negedge clk);
                        chk("t6_w5_stall", cpu_ready, 0);
                    end
                    ch_ack = 4'b0001;
                end
                wait_ready(40, n);
                if (w < 5) chk("t6_post_latency", n, 1);
                else       chk("t6_w5_after_ack", acks - base, 1);
                chk("t6_ready", cpu_ready, 1);
                cpu_req = 1'b0; cpu_we = 1'b0;
                @(negedge clk);
            end
            cpu_req = 1'b1; cpu_addr = 32'hD000_0000; ch_ack = 4'b0011;
            wait_ready(60, n);
            chk("t6_read_ready", cpu_ready, 1);
            chk("t6_drained", acks - base, 5);
            chk("t6_read_rdata", cpu_rdata, 32'h1111_2222);
            cpu_req = 1'b0; ch_ack = '0;
            @(negedge clk);
        end
`endif

        // err_count saturates at 255 under a stream of unmapped reads
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_0000;
        repeat (800) @(negedge clk);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_errcnt", err_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
